relu_maxpool_stage: RTL
=======================

Name: relu_maxpool_stage

Overview:
- Sits directly downstream of the bias-add stage. Consumes the `array_size` parallel signed lanes of bias-added convolution output.
- Per lane: applies optional ReLU, then a 1-D max-pool over `pool_len` consecutive accepted beats.
- Emits one pooled vector per window through a single-entry valid/ready output register feeding the feature-map writeback.

Parameters:
- data_size, 16, width of each signed lane.
- array_size, 9, number of parallel lanes (matches PE array columns).
- pool_len, 4, beats per pooling window; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset.
- relu_en  input  1  1 = clamp negative lanes to 0 before pooling; 0 = pass through.
- in_valid  input  1  input beat present; integrator drives it as AND of the adder's per-lane done bits.
- in_data  input  array_size*data_size  packed signed lanes; lane i at [(i+1)*data_size-1 : i*data_size].
- in_ready  output  1  stage can accept a beat this cycle.
- flush  input  1  close the current partial window.
- out_valid  output  1  out_data holds a pooled vector.
- out_data  output  array_size*data_size  pooled lanes, same packing as in_data.
- out_ready  input  1  consumer takes out_data this cycle.
- win_cnt  output  $clog2(pool_len+1)  beats accumulated in the open window.

Behaviour:
- Reset (reset==0 at posedge) clears win_cnt, out_valid, out_data and all lane max registers to 0. This overrides every other input, including a mid-window or pending-output state; partial data is discarded.
- A beat is accepted when in_valid && in_ready at posedge.
- ReLU is combinational: r_i = (relu_en && in_i[MSB]) ? 0 : in_i.
- Per accepted beat:
  - if win_cnt==0: max_i <= r_i
  - else: max_i <= signed max(max_i, r_i)
  - win_cnt increments.
- Window close occurs on:
  - an accepted beat with win_cnt==pool_len-1, or
  - flush==1 with win_cnt!=0 (the beat, if accepted that same cycle, is included first).
- On close:
  - out_data <= final lane maxima (including the closing beat); out_valid <= 1; win_cnt <= 0.
  - Latency: out_valid rises on the cycle after the closing beat.
- flush with win_cnt==0 and no accepted beat: no effect. flush with win_cnt==0 and an accepted beat: a 1-beat window closes.
- Output slot free = !out_valid || out_ready.
- in_ready = slot free || (win_cnt != pool_len-1).
- A flush close also requires a free slot. If the slot is busy, the flush is held internally (pending_flush) and executes on the first cycle the slot is free. in_ready is 0 while pending_flush is set.
- Drain and refill in the same cycle: out_data is replaced and out_valid stays 1, with no bubble. Drain with no close: out_valid <= 0.
- out_data is stable while out_valid && !out_ready.
- pool_len==1: every accepted beat closes a window; the stage degenerates to a ReLU plus a registered skid slot.
- Arithmetic: signed comparison only; no width growth, no saturation. The most negative value (0x8000) is handled as the minimum.
- relu_en is sampled per beat. Changing it mid-window is legal and affects only subsequent beats.

Decomposition:
- Shared package cnn_pkg holds:
  - default DATA_SIZE=16 and ARRAY_SIZE=9
  - a lane-slice helper function
  - the CNT_W = $clog2(POOL_LEN+1) computation
- One natural sub-module, lane_relu_max: per-lane combinational ReLU plus the signed-max register with its load/compare control. It is instantiated array_size times in a generate loop.
- Counter, flush pending and output handshake stay in the top.

Test Plan:
- Basic pool: pool_len=4, relu_en=0, lane0 beats 5,-3,12,7 back-to-back, out_ready=1 → out_valid pulses one cycle after beat 4 with lane0=12; win_cnt sequence 1,2,3,0.
- ReLU: relu_en=1, lane2 beats -8,-1,-20,-5 → lane2=0; same beats with relu_en=0 → lane2=-1 (0xFFFF).
- Backpressure: out_ready=0 with an output pending; send 3 more beats → accepted. 4th beat: in_ready=0 until out_ready=1. Raise out_ready and the 4th beat in the same cycle → next cycle holds the new window's max with out_valid continuously 1.
- Flush: 2 beats 100,-100, then flush with in_valid=0 → lane=100 emitted, win_cnt=0. Flush alone with win_cnt=0 → no out_valid.
- Extremes: lanes 0x8000,0x7FFF,0x8000,0x8000 → 0x7FFF; all 0x8000 with relu_en=0 → 0x8000.
- Reset mid-operation: after 2 beats with an output pending, drive reset=0 for one cycle → out_valid=0, win_cnt=0, out_data=0. Next 4 beats 1,2,3,4 → output 4, with no stale max carried over.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages: default lane geometry and
// small elaboration-time helpers for slicing packed lane vectors.
package cnn_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned ARRAY_SIZE = 9;

  function automatic int unsigned cnt_w(input int unsigned pool_len);
    return $clog2(pool_len + 1);
  endfunction

  // LSB position of a lane inside a packed vector of equal-width lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_relu_max.sv
// One pooling lane: combinational ReLU followed by a running signed-max register.
module lane_relu_max
  import cnn_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 relu_en,
  input  logic                 load,
  input  logic                 first,
  input  logic [data_size-1:0] in_lane,
  output logic [data_size-1:0] max_next
);

  logic [data_size-1:0] r;
  logic [data_size-1:0] max_q;

  // max_next is the post-beat maximum; the top captures it directly on a window close.
  always_comb begin
    r        = (relu_en && in_lane[data_size-1]) ? '0 : in_lane;
    max_next = max_q;
    if (load) begin
      if (first || ($signed(r) > $signed(max_q))) begin
        max_next = r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_next;
    end
  end

endmodule

// File: rtl/relu_maxpool_stage.sv
// ReLU + 1-D max-pool over pool_len accepted beats, with a single-entry
// valid/ready output register and flush support for partial windows.
module relu_maxpool_stage
  import cnn_pkg::*;
#(
  parameter int unsigned data_size  = DATA_SIZE,
  parameter int unsigned array_size = ARRAY_SIZE,
  parameter int unsigned pool_len   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            relu_en,
  input  logic                            in_valid,
  input  logic [array_size*data_size-1:0] in_data,
  output logic                            in_ready,
  input  logic                            flush,
  output logic                            out_valid,
  output logic [array_size*data_size-1:0] out_data,
  input  logic                            out_ready,
  output logic [cnt_w(pool_len)-1:0]      win_cnt
);

  localparam int unsigned          CNT_W = cnt_w(pool_len);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(pool_len - 1);

  logic                            pending_flush;
  logic                            slot_free;
  logic                            accept;
  logic                            flush_req;
  logic                            flush_has_data;
  logic                            close;
  logic [array_size*data_size-1:0] lane_next;

  always_comb begin
    slot_free      = !out_valid || out_ready;
    in_ready       = !pending_flush && (slot_free || (win_cnt != LAST));
    accept         = in_valid && in_ready;
    flush_req      = flush || pending_flush;
    flush_has_data = (win_cnt != '0) || accept;
    // A full-window close implies a free slot, since in_ready gates the last beat on it.
    close          = (accept && (win_cnt == LAST)) || (flush_req && flush_has_data && slot_free);
  end

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    lane_relu_max #(
      .data_size(data_size)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .relu_en (relu_en),
      .load    (accept),
      .first   (win_cnt == '0),
      .in_lane (in_data[lane_lsb(i, data_size) +: data_size]),
      .max_next(lane_next[lane_lsb(i, data_size) +: data_size])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt       <= '0;
      pending_flush <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
    end else if (close) begin
      out_data      <= lane_next;
      out_valid     <= 1'b1;
      win_cnt       <= '0;
      pending_flush <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        win_cnt <= win_cnt + CNT_W'(1);
      end
      pending_flush <= flush_req && flush_has_data;
    end
  end

endmodule
